// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among N_REQ byte producers.
// Round-robin grant with a bounded burst, optional ID header byte per grant,
// tx_start/tx_done sequencing and a tx_done watchdog that aborts the grant.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ID_HDR    = 1,
  parameter logic [7:0]  HDR_BASE  = 8'hA0,
  parameter int unsigned TIMEOUT   = 60000,
  localparam int unsigned IDW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HWAIT,
    LOAD,
    START,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDW-1:0]   last;
  logic [BCW-1:0]   burst_cnt;
  logic [WDW-1:0]   wdog;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [IDW-1:0]   ld_id;
  logic             wd_hit;
  logic             abort;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(last) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next state; tx_done is only honoured in HWAIT/WAIT and beats the watchdog.
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    wd_hit  = (TIMEOUT != 0) && (wdog == WD_LIMIT);
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n = (ID_HDR != 0) ? HDR : LOAD;
        end
      end
      HDR:   state_n = HWAIT;
      HWAIT: begin
        if (tx_done) begin
          state_n = LOAD;
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      LOAD:  state_n = START;
      START: state_n = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (req_valid[grant_id] && (burst_cnt < BURST_MAX)) begin
            state_n = LOAD;
          end else begin
            state_n = IDLE;
          end
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Requester whose ready is raised on entry to LOAD: the fresh pick when
  // coming straight from IDLE (no header), otherwise the held grant.
  always_comb begin
    ld_id = (state == IDLE) ? pick : grant_id;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Grant bookkeeping, burst counter, watchdog and the outgoing byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id  <= '0;
      last      <= IDW'(N_REQ - 1);
      burst_cnt <= '0;
      wdog      <= '0;
      tx_data   <= '0;
    end else begin
      // Every path into HWAIT/WAIT is a state change, so clearing on any
      // change is the same as clearing on entry.
      if (state_n != state) begin
        wdog <= '0;
      end else if ((state == HWAIT) || (state == WAIT)) begin
        wdog <= wdog + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (state_n != IDLE) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            if (ID_HDR != 0) begin
              tx_data <= HDR_BASE | 8'(pick);
            end
          end
        end
        LOAD: begin
          tx_data   <= req_data[{grant_id, 3'b000} +: 8];
          burst_cnt <= burst_cnt + 1'b1;
        end
        HWAIT, WAIT: begin
          if (state_n == IDLE) begin
            last <= grant_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      req_ready   <= '0;
    end else begin
      tx_start    <= (state_n == HDR) || (state_n == START);
      busy        <= (state_n != IDLE);
      timeout_err <= abort;
      req_ready   <= '0;
      if (state_n == LOAD) begin
        req_ready[ld_id] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of grant scenarios plus hand-written
// sequences for watchdog abort, stray tx_done and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int MB  = 2;
  localparam int DLY = 3;
  localparam logic [7:0] HB = 8'hA0;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(
    .N_REQ(NR),
    .MAX_BURST(MB),
    .ID_HDR(1),
    .HDR_BASE(HB),
    .TIMEOUT(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Requester byte sources.
  logic [7:0] rbuf [NR][8];
  int rcnt [NR];
  int rhead [NR];
  int rdy_pulses [NR];

  // Scoreboard of expected tx_start bytes.
  typedef struct packed {
    logic [7:0] b;
    logic [3:0] id;
    logic       pay;
  } exp_t;
  exp_t expq[$];

  // Scenario record: fields in order nb (nibble i = bytes from requester i),
  // seed, order (nibble k = k-th expected grant), norder.
  typedef struct packed {
    logic [3:0][3:0] nb;
    logic [7:0]      seed;
    logic [7:0][3:0] order;
    logic [3:0]      norder;
  } vec_t;
  vec_t vt [6];

  // uart_tx model state and controls.
  int  starts = 0;
  int  drop_at = -1;
  int  early_at = -1;
  bit  inject_done = 0;
  bit  pending = 0;
  int  dcnt = 0;
  bit  outstanding = 0;
  int  last_done_cyc = 0;
  int  drop_start_cyc = 0;
  int  err_cyc = 0;
  int  err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] b, input int id, input bit pay);
    exp_t e;
    e.b   = b;
    e.id  = 4'(id);
    e.pay = pay;
    return e;
  endfunction

  function automatic logic [7:0] dat(input logic [7:0] seed, input int i, input int j);
    return 8'(seed + 16 * i + j);
  endfunction

  task automatic load_req(input int i, input int n, input logic [7:0] seed);
    for (int j = 0; j < n; j++) rbuf[i][j] = dat(seed, i, j);
    rhead[i] = 0;
    rcnt[i] = n;
    rdy_pulses[i] = 0;
  endtask

  task automatic load_vec(input vec_t v);
    int rem [NR];
    for (int i = 0; i < NR; i++) begin
      rem[i] = int'(v.nb[i]);
      load_req(i, int'(v.nb[i]), v.seed);
    end
    for (int k = 0; k < int'(v.norder); k++) begin
      int id;
      id = int'(v.order[k]);
      expq.push_back(mk(HB | 8'(id), id, 1'b0));
      for (int j = 0; j < MB && rem[id] > 0; j++) begin
        expq.push_back(mk(dat(v.seed, id, int'(v.nb[id]) - rem[id]), id, 1'b1));
        rem[id]--;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || busy || req_valid != '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still expected, busy=%0b, required empty and idle",
               tag, expq.size(), busy);
      expq.delete();
    end
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic finish_vec(input vec_t v, input string tag);
    wait_drain(tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_ready_pulses_r%0d", tag, i), rdy_pulses[i], int'(v.nb[i]));
  endtask

  // Requester driver: sample ready mid-cycle, advance after the consuming edge.
  initial begin
    logic [NR-1:0] rdy_s;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      rcnt[i] = 0;
      rhead[i] = 0;
      rdy_pulses[i] = 0;
    end
    forever begin
      @(negedge clk);
      rdy_s = req_ready;
      if (rdy_s != '0) begin
        check("ready_onehot", $countones(rdy_s), 1);
        check("ready_without_valid", rdy_s & ~req_valid, 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rdy_s[i]) begin
          rdy_pulses[i]++;
          if (rhead[i] < rcnt[i]) rhead[i]++;
        end
        if (rhead[i] < rcnt[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rbuf[i][rhead[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx model and scoreboard consumer.
  initial begin
    exp_t e;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_done) tx_done = 1'b0;
      if (inject_done) begin
        tx_done = 1'b1;
        inject_done = 0;
      end
      if (timeout_err) begin
        err_pulses++;
        err_cyc = cyc;
        outstanding = 0;
      end
      if (tx_start) begin
        check("single_start", outstanding, 0);
        outstanding = 1;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got byte %0h id %0d, expected no start", tx_data, grant_id);
        end else begin
          e = expq.pop_front();
          check("tx_data", tx_data, e.b);
          check("grant_id", grant_id, e.id);
          if (e.pay) check("done_to_start_gap", cyc - last_done_cyc, 2);
        end
        if (starts == drop_at) begin
          drop_start_cyc = cyc;
          pending = 0;
        end else begin
          pending = 1;
          dcnt = DLY;
        end
        if (starts == early_at) tx_done = 1'b1;
        starts++;
      end else if (pending) begin
        dcnt--;
        if (dcnt == 0) begin
          tx_done = 1'b1;
          pending = 0;
          outstanding = 0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0;
    int n;
    vt[0] = {16'h1111, 8'h00, 32'h0000_3210, 4'd4};
    vt[1] = {16'h3333, 8'h01, 32'h3210_3210, 4'd8};
    vt[2] = {16'h0100, 8'h35, 32'h0000_0002, 4'd1};
    vt[3] = {16'h0110, 8'h40, 32'h0000_0021, 4'd2};
    vt[4] = {16'h2003, 8'h08, 32'h0000_0003, 4'd3};
    vt[5] = {16'h0011, 8'h60, 32'h0000_0001, 4'd2};

    // Reset held with every requester valid: nothing moves, then 0 goes first.
    reset = 1'b0;
    load_vec(vt[0]);
    repeat (4) @(negedge clk);
    check("rst_valids_high", req_valid, 4'hF);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    finish_vec(vt[0], "t1");

    for (int v = 1; v < 6; v++) begin
      load_vec(vt[v]);
      finish_vec(vt[v], $sformatf("vec%0d", v));
    end

    // Watchdog: the first payload byte of requester 1 never completes.
    for (int i = 0; i < NR; i++) load_req(i, 0, 8'h00);
    load_req(1, 2, 8'h70);
    load_req(2, 1, 8'h70);
    err_pulses = 0;
    drop_at = starts + 1;
    expq.push_back(mk(8'hA1, 1, 1'b0));
    expq.push_back(mk(8'h80, 1, 1'b1));
    expq.push_back(mk(8'hA2, 2, 1'b0));
    expq.push_back(mk(8'h90, 2, 1'b1));
    expq.push_back(mk(8'hA1, 1, 1'b0));
    expq.push_back(mk(8'h81, 1, 1'b1));
    wait_drain("t5");
    drop_at = -1;
    check("t5_err_pulses", err_pulses, 1);
    // 100 cycles in WAIT after the start cycle, then the registered pulse.
    check("t5_err_delay", err_cyc - drop_start_cyc, 101);
    check("t5_ready_r1", rdy_pulses[1], 2);
    check("t5_ready_r2", rdy_pulses[2], 1);

    // Stray tx_done while idle.
    @(negedge clk);
    inject_done = 1;
    repeat (4) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_start", tx_start, 0);
    check("t6_idle_ready", req_ready, 0);
    check("t6_idle_grant", grant_id, 1);

    // tx_done coinciding with START is ignored; the real one follows.
    load_req(0, 1, 8'hC0);
    early_at = starts + 1;
    expq.push_back(mk(8'hA0, 0, 1'b0));
    expq.push_back(mk(8'hC0, 0, 1'b1));
    wait_drain("t6_start");
    early_at = -1;
    check("t6_start_ready_r0", rdy_pulses[0], 1);
    check("t6_start_err_pulses", err_pulses, 1);

    // Asynchronous reset while waiting for a payload tx_done.
    load_req(3, 1, 8'h05);
    s0 = starts;
    drop_at = s0 + 1;
    expq.push_back(mk(8'hA3, 3, 1'b0));
    expq.push_back(mk(8'h35, 3, 1'b1));
    n = 0;
    while (starts < s0 + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6_rst_reached_wait", n < 300, 1);
    repeat (5) @(negedge clk);
    check("t6_rst_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    pending = 0;
    outstanding = 0;
    #1;
    check("t6_rst_tx_start", tx_start, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_grant", grant_id, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_queue", expq.size(), 0);
    drop_at = -1;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_post_busy", busy, 0);
    check("t6_post_ready_r3", rdy_pulses[3], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
